wbc_rr_arbiter_wdog: RTL
========================

Name: wbc_rr_arbiter_wdog

Overview:
Round-robin grant controller for the shared WISHBONE control bus. It arbitrates NUM_MASTERS cycle requests (bmc, spic, pciec) and drives the one-hot grant vector used by the interconnect's mux. A per-transfer watchdog terminates any strobe the selected slave never acknowledges: it returns a single-cycle error to the granted master and suppresses the slave-side cycle until that master releases the bus. Timeout events are counted and the offending master is recorded for the ID/control register block.

Parameters:
NUM_MASTERS, 3, number of requesting masters (index 0 = bmc, 1 = spic, 2 = pciec)
TIMEOUT, 1024, cycles of unacknowledged strobe before abort; 0 disables the watchdog
CNT_WIDTH, 16, width of the timeout event counter

Ports:
clk_i  in  1  bus clock
rst_i  in  1  synchronous reset, active high
cyc_i  in  NUM_MASTERS  per-master WISHBONE cyc
stb_i  in  NUM_MASTERS  per-master WISHBONE stb
ack_i  in  1  muxed slave ack
err_i  in  1  muxed slave err
rty_i  in  1  muxed slave rty
gnt_o  out  NUM_MASTERS  one-hot grant, registered
abort_o  out  1  high while the slave-side cyc/stb must be forced low
tmo_err_o  out  1  injected err, ORed into errs for the granted master
tmo_count_o  out  CNT_WIDTH  saturating count of watchdog aborts
tmo_master_o  out  NUM_MASTERS  one-hot grant captured at the most recent abort
clr_count_i  in  1  synchronous clear of tmo_count_o and tmo_master_o

Behaviour:
- Reset values: gnt_o=0, abort_o=0, tmo_err_o=0, tmo_count_o=0, tmo_master_o=0. Priority pointer = 0 (bmc has first priority). Watchdog counter = 0. State = IDLE.
- Reset asserted mid-transfer returns to these values on the next edge, regardless of state.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - If cyc_i != 0, select the first requester at or after the pointer, searching upward with wrap-around.
  - Next cycle: gnt_o = that one-hot; state = GRANT.
  - Grant latency is 1 clock from the cyc_i rise.
- GRANT (g = granted index):
  - While cyc_i[g]=1, gnt_o holds. Other requests are ignored (no preemption).
  - When cyc_i[g]=0: next cycle gnt_o=0, pointer = (g+1) mod NUM_MASTERS, state = IDLE.
  - Consequence: exactly one dead cycle between consecutive grants, even when the same master re-requests.
- Watchdog (GRANT only, TIMEOUT>0):
  - Counter clears when stb_i[g]=0 or when any of ack_i|err_i|rty_i is high.
  - Otherwise it increments by 1 per cycle.
  - When the counter equals TIMEOUT-1 and no termination is present that cycle, the next edge moves to ABORT, sets tmo_err_o=1, abort_o=1, tmo_master_o=gnt_o, and increments tmo_count_o (saturates at all-ones).
  - If a termination arrives in the threshold cycle, the termination wins: no abort, counter clears.
- ABORT:
  - tmo_err_o is high for exactly one cycle (the first ABORT cycle), then 0.
  - abort_o stays high and gnt_o holds until cyc_i[g]=0. The next cycle then does gnt_o=0, abort_o=0, pointer=g+1, state=IDLE.
  - Late ack_i/err_i/rty_i during ABORT are ignored.
  - If cyc_i[g] drops in the same cycle tmo_err_o is high, the exit follows the normal path: IDLE on the next edge.
- clr_count_i: clears tmo_count_o and tmo_master_o next edge. If it coincides with an abort, the result is tmo_count_o=1 and tmo_master_o = the new capture.
- TIMEOUT=0: state never enters ABORT; abort_o and tmo_err_o are constant 0.
- Watchdog counter width: clog2(TIMEOUT+1), minimum 1.

Test Plan:
- Reset, then cyc_i=3'b111 held → gnt_o=001 one cycle later. Drop cyc_i[0] → gnt_o=000 for one cycle, then 010. Repeat for 100; then 001 again (full rotation).
- cyc_i[2] only, released and reasserted immediately → gnt_o sequence 100,000,100, with the pointer moved to 0 after each release.
- TIMEOUT=8, granted master holds stb with no ack → tmo_err_o high exactly on cycle 9 after stb rise. abort_o stays high until cyc drops. tmo_count_o=1, tmo_master_o = that grant.
- TIMEOUT=8, ack_i asserted on stb cycle 8 (threshold cycle) → no abort, tmo_count_o unchanged. Back-to-back stb restarts the count from 0.
- Force tmo_count_o to all-ones via repeated aborts with CNT_WIDTH=2 → saturates at 3. Then clr_count_i → 0. Next clr coincident with an abort → 1.
- rst_i asserted during ABORT with cyc held → all outputs 0 next edge. After release, the first grant goes to master 0.

Source files
------------

// File: rtl/wbc_rr_arbiter_wdog_if.sv
// Control-bus arbitration signals between the masters/slave mux and the
// round-robin grant controller.
interface wbc_rr_arbiter_wdog_if #(
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0] cyc_i;
  logic [NUM_MASTERS-1:0] stb_i;
  logic                   ack_i;
  logic                   err_i;
  logic                   rty_i;
  logic [NUM_MASTERS-1:0] gnt_o;
  logic                   abort_o;
  logic                   tmo_err_o;

  modport slave (
    input  cyc_i, stb_i, ack_i, err_i, rty_i,
    output gnt_o, abort_o, tmo_err_o
  );

  modport master (
    output cyc_i, stb_i, ack_i, err_i, rty_i,
    input  gnt_o, abort_o, tmo_err_o
  );
endinterface

// File: rtl/wbc_rr_arbiter_wdog.sv
// Round-robin grant controller for the WISHBONE control bus with a
// per-transfer watchdog that aborts strobes the slave never terminates.
module wbc_rr_arbiter_wdog #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wbc_rr_arbiter_wdog_if.slave   bus,
  output logic [CNT_WIDTH-1:0]   tmo_count_o,
  output logic [NUM_MASTERS-1:0] tmo_master_o,
  input  logic                   clr_count_i
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST =
    (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t                 state;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          gidx;
  logic [WW-1:0]          wd;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   abort;
  logic                   tmo_err;

  logic [IW-1:0] sel;
  logic          found;
  logic [IW-1:0] nxt_ptr;
  logic          term;
  logic          hold;
  logic          strobe;
  logic          hit;

  // first requester at or after the pointer, wrapping upward
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j     = 0;
    jj    = '0;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      jj = IW'(j);
      if (!found && bus.cyc_i[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  assign nxt_ptr = (gidx == IW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
  assign term    = bus.ack_i | bus.err_i | bus.rty_i;
  assign hold    = bus.cyc_i[gidx];
  assign strobe  = bus.stb_i[gidx];
  assign hit     = (TIMEOUT > 0) && strobe && !term && (wd == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      gidx         <= '0;
      wd           <= '0;
      gnt          <= '0;
      abort        <= 1'b0;
      tmo_err      <= 1'b0;
      tmo_count_o  <= '0;
      tmo_master_o <= '0;
    end else begin
      tmo_err <= 1'b0;
      if (clr_count_i) begin
        tmo_count_o  <= '0;
        tmo_master_o <= '0;
      end
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (found) begin
            gidx  <= sel;
            gnt   <= NUM_MASTERS'(1) << sel;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!hold) begin
            gnt   <= '0;
            ptr   <= nxt_ptr;
            wd    <= '0;
            state <= IDLE;
          end else if (hit) begin
            state        <= ABORT;
            tmo_err      <= 1'b1;
            abort        <= 1'b1;
            wd           <= '0;
            tmo_master_o <= gnt;
            // a coincident clear restarts the count at this abort
            if (clr_count_i)
              tmo_count_o <= CNT_WIDTH'(1);
            else if (tmo_count_o != CNT_MAX)
              tmo_count_o <= tmo_count_o + 1'b1;
          end else if (!strobe || term || TIMEOUT == 0) begin
            wd <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ABORT: begin
          if (!hold) begin
            gnt   <= '0;
            abort <= 1'b0;
            ptr   <= nxt_ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.abort_o   = abort;
  assign bus.tmo_err_o = tmo_err;
endmodule
